// File: rtl/e_mdu_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mdu_defs: shared definitions for the E-stage multiply/divide unit.
//   - MDOP_* : 3-bit MD operation encodings, shared with the control unit
//              that decodes E_mdop.
//   - MULT_CYCLES_DEF / DIV_CYCLES_DEF : default operation latencies.
//   - mdu_state_e : scheduler FSM states.
// ---------------------------------------------------------------------------
package mdu_defs;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the four ops that occupy the MDU for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_scheduler_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith: combinational MDU datapath.
//   op     in  3        MDOP_* encoding
//   a, b   in  WIDTH    operands (rs, rt)
//   result out 2*WIDTH  {hi, lo}; mult -> product, div -> {remainder, quotient}
//   div0   out 1        div/divu with b == 0 (caller must leave HI/LO alone)
// ---------------------------------------------------------------------------
module mdu_arith
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      ovf;
  logic        [WIDTH-1:0]   div_bs;
  logic        [WIDTH-1:0]   div_bu;
  logic signed [WIDTH-1:0]   q_s;
  logic signed [WIDTH-1:0]   r_s;
  logic        [WIDTH-1:0]   q_u;
  logic        [WIDTH-1:0]   r_u;

  // NOTE: every signal written here gets a value on every path first, so no
  // latch can be inferred.
  always_comb begin
    prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // MIN / -1 overflows; dividing by 1 instead yields exactly the wanted
    // quotient (MIN) and remainder (0). A zero divisor is likewise replaced
    // so the dividers never see 0; the div0 flag suppresses the commit.
    ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    div_bs = ((b == '0) || ovf) ? WIDTH'(1) : b;
    div_bu = (b == '0) ? WIDTH'(1) : b;

    q_s = $signed(a) / $signed(div_bs);
    r_s = $signed(a) % $signed(div_bs);
    q_u = a / div_bu;
    r_u = a % div_bu;

    result = '0;
    div0   = 1'b0;
    case (op)
      MDOP_MULT:  result = prod_s;
      MDOP_MULTU: result = prod_u;
      MDOP_DIV: begin
        result = {r_s, q_s};
        div0   = (b == '0);
      end
      MDOP_DIVU: begin
        result = {r_u, q_u};
        div0   = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_scheduler.sv
// ---------------------------------------------------------------------------
// e_mdu_scheduler: E-stage multiply/divide sequencer owning HI/LO.
//   clk      in  1      system clock
//   reset    in  1      synchronous, active-high
//   E_mdop   in  3      MDOP_* op from the E-stage control unit
//   E_a/E_b  in  WIDTH  forwarded rs / rt values
//   D_is_md  in  1      D-stage instruction is an MD instruction
//   start    out 1      long op accepted this cycle (comb)
//   busy     out 1      MDU running (registered state)
//   md_stall out 1      stall request to the hazard unit (comb)
//   hi, lo   out WIDTH  architectural HI / LO
// The result is computed when the op is accepted and parked in shadow
// registers; HI/LO only change on the final RUN edge, after N busy cycles.
// ---------------------------------------------------------------------------
module e_mdu_scheduler
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       E_mdop,
  input  logic [WIDTH-1:0] E_a,
  input  logic [WIDTH-1:0] E_b,
  input  logic             D_is_md,
  output logic             start,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   shadow_hi, shadow_lo;
  logic               shadow_div0;
  logic [2*WIDTH-1:0] arith_result;
  logic               arith_div0;
  logic               is_div;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (E_mdop),
    .a      (E_a),
    .b      (E_b),
    .result (arith_result),
    .div0   (arith_div0)
  );

  assign is_div = (E_mdop == MDOP_DIV) || (E_mdop == MDOP_DIVU);
  assign start  = is_long_op(E_mdop) && (state_q == ST_IDLE);
  assign busy   = (state_q == ST_RUN);
  // Built only from D_is_md, start and busy: never from hi/lo, so no loop
  // forms through the D-stage forwarding muxes.
  assign md_stall = D_is_md && (start || busy);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)         state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      shadow_hi   <= '0;
      shadow_lo   <= '0;
      shadow_div0 <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        {shadow_hi, shadow_lo} <= arith_result;
        shadow_div0            <= arith_div0;
        cnt_q                  <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if (E_mdop == MDOP_MTHI) begin
        hi <= E_a;
      end else if (E_mdop == MDOP_MTLO) begin
        lo <= E_a;
      end
    end else begin
      // RUN: mthi/mtlo and new starts are ignored here.
      if (cnt_q == '0) begin
        if (!shadow_div0) begin
          hi <= shadow_hi;
          lo <= shadow_lo;
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for e_mdu_scheduler. Expected HI/LO come from a 64-bit integer
// model of the MD instructions; expected latencies from the op class.
// Inputs are driven and outputs sampled at the falling edge.
// ---------------------------------------------------------------------------
module tb_e_mdu_scheduler;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   E_mdop;
  logic [W-1:0] E_a, E_b;
  logic         D_is_md;
  logic         start, busy, md_stall;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int passes = 0;
  int protocol_err = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  e_mdu_scheduler #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_mdop   (E_mdop),
    .E_a      (E_a),
    .E_b      (E_b),
    .D_is_md  (D_is_md),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // The hazard unit never issues an MD op into a running MDU; the bench
  // honours that and flags itself if it ever does.
  always @(posedge clk) begin
    if (!reset && busy && (E_mdop >= 3'd1) && (E_mdop <= 3'd6)) protocol_err++;
  end

  // Reference: {hi, lo} after op, given current hi/lo.
  function automatic logic [63:0] model_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    model_md = {cur_hi, cur_lo};
    sa = a;
    sb = b;
    case (op)
      3'd1: begin ps = longint'(sa) * longint'(sb); model_md = ps; end
      3'd2: begin pu = longint'({32'b0, a}) * longint'({32'b0, b}); model_md = pu; end
      3'd3: begin
        if (b == 0)                              model_md = {cur_hi, cur_lo};
        else if (a == 32'h8000_0000 && sb == -1) model_md = {32'h0, 32'h8000_0000};
        else                                     model_md = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: if (b != 0) model_md = {a % b, a / b};
      3'd5: model_md = {a, cur_lo};
      3'd6: model_md = {cur_hi, a};
      default: ;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Called at a falling edge with the MDU idle; returns at the falling edge
  // where busy first reads 0 (so calls chain back-to-back).
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic d);
    int          n;
    int          exp_n;
    logic        exp_start;
    logic [63:0] nxt;
    exp_start = (op >= 3'd1 && op <= 3'd4);
    exp_n     = model_latency(op);
    nxt       = model_md(op, a, b, exp_hi, exp_lo);
    E_mdop = op; E_a = a; E_b = b; D_is_md = d;
    #1;
    checks++;
    if (start !== exp_start) $display("FAIL %s start: got %b want %b", name, start, exp_start);
    else passes++;
    checks++;
    if (md_stall !== (d & exp_start))
      $display("FAIL %s md_stall@issue: got %b want %b", name, md_stall, d & exp_start);
    else passes++;
    @(posedge clk); #1;
    E_mdop = 3'd0; E_a = $urandom; E_b = $urandom;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      checks++;
      if (md_stall !== d || hi !== exp_hi || lo !== exp_lo)
        $display("FAIL %s busy cycle %0d: md_stall=%b hi=%h lo=%h want %b %h %h",
                 name, n, md_stall, hi, lo, d, exp_hi, exp_lo);
      else passes++;
    end
    {exp_hi, exp_lo} = nxt;
    checks++;
    if (n !== exp_n) $display("FAIL %s busy cycles: got %0d want %0d", name, n, exp_n);
    else passes++;
    checks++;
    if (hi !== exp_hi || lo !== exp_lo)
      $display("FAIL %s hi/lo: got %h/%h want %h/%h", name, hi, lo, exp_hi, exp_lo);
    else passes++;
    checks++;
    if (md_stall !== 1'b0) $display("FAIL %s md_stall after: got %b want 0", name, md_stall);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1; E_mdop = 3'd0; E_a = '0; E_b = '0; D_is_md = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || md_stall !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL reset: busy=%b start=%b md_stall=%b hi=%h lo=%h want all 0",
               busy, start, md_stall, hi, lo);
    else passes++;
  endtask

  task automatic test_directed();
    run_op("T1 mult",     3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
      $display("FAIL T1 const: got %h/%h want ffffffff/fffffffa", hi, lo);
    else passes++;
    run_op("T2 multu",    3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE)
      $display("FAIL T2 const: got %h/%h want 00000001/fffffffe", hi, lo);
    else passes++;
    run_op("T3 div",      3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
      $display("FAIL T3 const: got %h/%h want ffffffff/fffffffd", hi, lo);
    else passes++;
    run_op("T3b div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000)
      $display("FAIL T3b const: got %h/%h want 00000000/80000000", hi, lo);
    else passes++;
    run_op("divu ovf pattern", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mthi",        3'd5, 32'hCAFE_0001, 32'd0, 1'b0);
    run_op("T4 mtlo",     3'd6, 32'h0000_1234, 32'd0, 1'b0);
    run_op("T4 divu0",    3'd4, 32'd10, 32'd0, 1'b0);
    checks++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'h0000_1234)
      $display("FAIL T4 const: got %h/%h want cafe0001/00001234", hi, lo);
    else passes++;
    run_op("div0 signed", 3'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
    run_op("op7 none",    3'd7, 32'h1111_1111, 32'h2222_2222, 1'b1);
  endtask

  task automatic test_stall();
    // Back-to-back after run_op returns; D_is_md high throughout.
    run_op("T5 mult stall", 3'd1, 32'h0001_0003, 32'h0000_0007, 1'b1);
    run_op("T5 back2back",  3'd3, 32'd100, 32'd7, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    int n;
    E_mdop = 3'd3; E_a = 32'd12345; E_b = 32'd7; D_is_md = 1'b0;
    @(posedge clk); #1;
    E_mdop = 3'd0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n !== 3) $display("FAIL T6 busy before reset: got %0d want 3", n);
    else passes++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL T6 after reset: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    else passes++;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== '0 || lo !== '0) n++;
    end
    checks++;
    if (n !== 0) $display("FAIL T6 late commit: %0d bad cycles want 0", n);
    else passes++;
    run_op("T6 mult after reset", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("random", op, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_op();
    test_random();
    checks++;
    if (protocol_err !== 0) $display("FAIL protocol: %0d MD ops while busy, want 0", protocol_err);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
